beat_tracker: RTL and testbench
===============================

BEAT_TRACKER -- requirements
Module: beat_tracker

Interface
REQ-001 DATA_BITS, 17, sample magnitude width, unsigned.
REQ-002 PERIOD_BITS, 11, width of period counter and period outputs.
REQ-003 THRESH_HI, 70000, transient trigger level; a sample strictly above it is a candidate beat.
REQ-004 THRESH_LO, 20000, re-arm level; a sample strictly below it re-arms detection.
REQ-005 MIN_PERIOD, 1181, minimum samples between beats; MAX_PERIOD, 1378, timeout point; MIN_PERIOD < MAX_PERIOD < 2^PERIOD_BITS.
REQ-006 AVG_DEPTH, 4, period history depth, power of 2, 2..16; TOL, 16, lock tolerance in samples; LOCK_COUNT, 4; MISS_LIMIT, 2.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 sample_valid  in  1  one sample accepted per cycle where high.
REQ-010 sample  in  DATA_BITS  envelope/energy magnitude.
REQ-011 beat_pulse  out  1  one-cycle pulse per beat, real or synthetic.
REQ-012 beat_synth  out  1  qualifies beat_pulse: 1 = timeout-inserted beat.
REQ-013 period_out  out  PERIOD_BITS  averaged beat period in samples.
REQ-014 locked  out  1  tempo lock indicator.

Function
REQ-015 count: increments by 1 on each sample_valid cycle, saturates at 2^PERIOD_BITS-1.
REQ-016 States IDLE, HOLDOFF, ARMED, BEAT, TIMEOUT; IDLE -> HOLDOFF unconditionally one cycle after reset.
REQ-017 HOLDOFF -> ARMED when count >= MIN_PERIOD; samples above THRESH_HI in HOLDOFF are ignored.
REQ-018 ARMED -> BEAT when sample_valid, sample > THRESH_HI and rearm flag = 1.
REQ-019 ARMED -> TIMEOUT when count >= MAX_PERIOD and BEAT condition false; BEAT wins on simultaneous conditions.
REQ-020 BEAT and TIMEOUT last exactly one cycle, then -> HOLDOFF.
REQ-021 Entering BEAT: record period = count value before the triggering sample, push into history (oldest dropped), count <= 0, rearm <= 0; triggering sample not counted.
REQ-022 beat_pulse=1, beat_synth=0 during BEAT (one cycle after triggering sample_valid).
REQ-023 Entering TIMEOUT: history unchanged, count <= MAX_PERIOD - period_out (phase continuation), miss counter +1; beat_pulse=1, beat_synth=1.
REQ-024 rearm set on any sample_valid cycle with sample < THRESH_LO, in any state except BEAT.
REQ-025 period_out = (sum of history) >> log2(AVG_DEPTH), truncating; sum width PERIOD_BITS+log2(AVG_DEPTH); updates one cycle after BEAT.
REQ-026 Real beat with |period - period_out| <= TOL (period_out before update): consecutive counter +1 (saturating), miss counter <= 0; otherwise consecutive counter <= 0, locked <= 0.
REQ-027 locked <= 1 when consecutive counter reaches LOCK_COUNT; locked <= 0 and consecutive counter <= 0 when miss counter reaches MISS_LIMIT.

Reset
REQ-028 On rst: state IDLE, count 0, rearm 1, every history entry MIN_PERIOD, period_out MIN_PERIOD, both counters 0, beat_pulse 0, beat_synth 0, locked 0.
REQ-029 rst asserted mid-operation (including during BEAT/TIMEOUT) discards all state per REQ-028 on the next edge; no pulse emitted while rst high.

Configuration
REQ-030 Macro BEAT_HYSTERESIS_EN defined: rearm behaves per REQ-021/REQ-024.
REQ-031 Macro BEAT_HYSTERESIS_EN undefined: rearm held constant 1; THRESH_LO unused; all other behaviour identical.

Verification
REQ-032 Reset, then 1400 samples of 0 -> single synthetic beat at sample 1378, beat_synth=1, count reloads to 197, period_out=1181.
REQ-033 Spikes of 80000 every 1200 samples, zeros between -> period_out 1185, 1190, 1195, 1200 after beats 1-4; locked rises with the 5th beat_pulse.
REQ-034 Spike 80000 at count 1000 in HOLDOFF -> no beat_pulse; spike at count 1181 -> beat, period 1181 recorded.
REQ-035 Hysteresis: beat, then samples held at 50000 past MIN_PERIOD, then 80000 -> no real beat (timeout at 1378) with macro defined; real beat at count 1181 with macro undefined.
REQ-036 Locked at period 1200, remove spikes for 2 periods -> two synthetic beats, locked falls with the second; rst mid-period -> period_out 1181, locked 0 next cycle.

Source files
------------

// File: rtl/beat_tracker_if.sv
// Sample stream into beat_tracker and the beat/tempo indications coming back out.
// master drives samples (source side); slave is the tracker.
interface beat_tracker_if #(
  parameter int DATA_BITS   = 17,
  parameter int PERIOD_BITS = 11
);
  logic                   sample_valid;
  logic [DATA_BITS-1:0]   sample;
  logic                   beat_pulse;
  logic                   beat_synth;
  logic [PERIOD_BITS-1:0] period_out;
  logic                   locked;

  modport master (
    output sample_valid, sample,
    input  beat_pulse, beat_synth, period_out, locked
  );

  modport slave (
    input  sample_valid, sample,
    output beat_pulse, beat_synth, period_out, locked
  );
endinterface

// File: rtl/beat_tracker.sv
// Transient-driven beat tracker with period averaging, timeout beat insertion and tempo lock.
// Define BEAT_HYSTERESIS_EN to require a sample below THRESH_LO before each new real beat.
module beat_tracker #(
  parameter int DATA_BITS   = 17,
  parameter int PERIOD_BITS = 11,
  parameter int THRESH_HI   = 70000,
  parameter int THRESH_LO   = 20000,
  parameter int MIN_PERIOD  = 1181,
  parameter int MAX_PERIOD  = 1378,
  parameter int AVG_DEPTH   = 4,
  parameter int TOL         = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int MISS_LIMIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  beat_tracker_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HOLDOFF = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] BEAT    = 3'd3;
  localparam logic [2:0] TIMEOUT = 3'd4;

  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam int SUM_BITS  = PERIOD_BITS + AVG_SHIFT;
  localparam int LC_BITS   = $clog2(LOCK_COUNT + 1);
  localparam int MC_BITS   = $clog2(MISS_LIMIT + 1);

  localparam logic [DATA_BITS-1:0]   HI        = DATA_BITS'(THRESH_HI);
  localparam logic [PERIOD_BITS-1:0] MIN_P     = PERIOD_BITS'(MIN_PERIOD);
  localparam logic [PERIOD_BITS-1:0] MAX_P     = PERIOD_BITS'(MAX_PERIOD);
  localparam logic [PERIOD_BITS-1:0] TOL_P     = PERIOD_BITS'(TOL);
  localparam logic [PERIOD_BITS-1:0] COUNT_SAT = {PERIOD_BITS{1'b1}};
  localparam logic [LC_BITS-1:0]     LOCK_C    = LC_BITS'(LOCK_COUNT);
  localparam logic [MC_BITS-1:0]     MISS_C    = MC_BITS'(MISS_LIMIT);

  logic [2:0]             state_reg, state_next;
  logic [PERIOD_BITS-1:0] count_reg, count_inc;
  logic [PERIOD_BITS-1:0] period_reg, period_diff;
  logic [PERIOD_BITS-1:0] hist_reg [AVG_DEPTH];
  logic [SUM_BITS-1:0]    hist_sum;
  logic [LC_BITS-1:0]     consec_reg, consec_inc;
  logic [MC_BITS-1:0]     miss_reg, miss_inc;
  logic                   locked_reg;
  logic                   rearm;
  logic                   beat_cond, enter_beat, enter_timeout, in_tol;

`ifdef BEAT_HYSTERESIS_EN
  localparam logic [DATA_BITS-1:0] LO = DATA_BITS'(THRESH_LO);
  logic rearm_reg;

  always_ff @(posedge clk) begin
    if (rst)
      rearm_reg <= 1'b1;
    else if (enter_beat)
      rearm_reg <= 1'b0;
    else if (bus.sample_valid && (bus.sample < LO) && (state_reg != BEAT))
      rearm_reg <= 1'b1;
  end

  assign rearm = rearm_reg;
`else
  localparam int unused_thresh_lo = THRESH_LO;
  assign rearm = 1'b1;
`endif

  assign count_inc  = (bus.sample_valid && (count_reg != COUNT_SAT)) ? count_reg + PERIOD_BITS'(1) : count_reg;
  assign consec_inc = (consec_reg == LOCK_C) ? consec_reg : consec_reg + LC_BITS'(1);
  assign miss_inc   = (miss_reg == MISS_C) ? miss_reg : miss_reg + MC_BITS'(1);

  // Tolerance is judged against the average as it stood before this beat.
  assign period_diff = (count_reg >= period_reg) ? count_reg - period_reg : period_reg - count_reg;
  assign in_tol      = (period_diff <= TOL_P);

  assign beat_cond     = bus.sample_valid && (bus.sample > HI) && rearm;
  assign enter_beat    = (state_reg == ARMED) && beat_cond;
  assign enter_timeout = (state_reg == ARMED) && !beat_cond && (count_reg >= MAX_P);

  always_comb begin
    hist_sum = '0;
    for (int i = 0; i < AVG_DEPTH; i++)
      hist_sum = hist_sum + SUM_BITS'(hist_reg[i]);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = HOLDOFF;
      // Arm on the sample that brings count to MIN_PERIOD so a spike at that count can fire.
      HOLDOFF: if (count_inc >= MIN_P) state_next = ARMED;
      ARMED: begin
        if (enter_beat)         state_next = BEAT;
        else if (enter_timeout) state_next = TIMEOUT;
      end
      BEAT:    state_next = HOLDOFF;
      TIMEOUT: state_next = HOLDOFF;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= MIN_P;
      for (int i = 0; i < AVG_DEPTH; i++)
        hist_reg[i] <= MIN_P;
      consec_reg <= '0;
      miss_reg   <= '0;
      locked_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (enter_beat)
        count_reg <= '0;
      else if (enter_timeout)
        count_reg <= MAX_P - period_reg;
      else
        count_reg <= count_inc;

      if (enter_beat) begin
        hist_reg[0] <= count_reg;
        for (int i = 1; i < AVG_DEPTH; i++)
          hist_reg[i] <= hist_reg[i-1];
      end

      if (state_reg == BEAT)
        period_reg <= PERIOD_BITS'(hist_sum >> AVG_SHIFT);

      if (enter_beat) begin
        if (in_tol) begin
          consec_reg <= consec_inc;
          miss_reg   <= '0;
          if (consec_inc == LOCK_C)
            locked_reg <= 1'b1;
        end else begin
          consec_reg <= '0;
          locked_reg <= 1'b0;
        end
      end else if (enter_timeout) begin
        miss_reg <= miss_inc;
        if (miss_inc == MISS_C) begin
          consec_reg <= '0;
          locked_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.beat_pulse = !rst && ((state_reg == BEAT) || (state_reg == TIMEOUT));
  assign bus.beat_synth = !rst && (state_reg == TIMEOUT);
  assign bus.period_out = period_reg;
  assign bus.locked     = locked_reg;
endmodule

// File: tb/tb_beat_tracker.sv
// Bench for beat_tracker: directed tables and sequences plus random stimulus against a rule-level model.
module tb_beat_tracker;
  localparam int DB = 17, PB = 11;
  localparam int HI = 70000, LO = 20000, MINP = 1181, MAXP = 1378;
  localparam int DEPTH = 4, TOL = 16, LOCKC = 4, MISSL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  beat_tracker_if #(.DATA_BITS(DB), .PERIOD_BITS(PB)) bus_if ();

  beat_tracker #(
    .DATA_BITS(DB), .PERIOD_BITS(PB), .THRESH_HI(HI), .THRESH_LO(LO),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .AVG_DEPTH(DEPTH), .TOL(TOL),
    .LOCK_COUNT(LOCKC), .MISS_LIMIT(MISSL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulses = 0;

  // Reference model: counts samples since the last beat; eligibility is simply count >= MIN_PERIOD.
  int m_count, m_pout, m_consec, m_miss;
  bit m_rearm, m_locked, m_pulse, m_synth, m_pending, m_in_beat;
  int m_hist[$];

  function automatic void model_reset();
    m_count = 0; m_pout = MINP; m_consec = 0; m_miss = 0;
    m_rearm = 1; m_locked = 0; m_pulse = 0; m_synth = 0;
    m_pending = 0; m_in_beat = 0;
    m_hist = {};
    for (int i = 0; i < DEPTH; i++) m_hist.push_back(MINP);
  endfunction

  function automatic void model_step(input bit r, input bit v, input int s);
    bit beat_ev, to_ev;
    int diff, sum;
    if (r) begin
      model_reset();
      return;
    end
    beat_ev = v && (s > HI) && m_rearm && (m_count >= MINP);
    to_ev   = !beat_ev && (m_count >= MAXP);
    if (m_pending) begin
      sum = 0;
      foreach (m_hist[i]) sum += m_hist[i];
      m_pout = sum / DEPTH;
      m_pending = 0;
    end
    if (beat_ev) begin
      diff = m_count - m_pout;
      if (diff < 0) diff = -diff;
      m_hist.push_front(m_count);
      void'(m_hist.pop_back());
      if (diff <= TOL) begin
        m_consec = (m_consec < LOCKC) ? m_consec + 1 : LOCKC;
        m_miss = 0;
        if (m_consec >= LOCKC) m_locked = 1;
      end else begin
        m_consec = 0;
        m_locked = 0;
      end
      m_count = 0;
      m_pending = 1;
    end else if (to_ev) begin
      m_count = MAXP - m_pout;
      m_miss = (m_miss < MISSL) ? m_miss + 1 : MISSL;
      if (m_miss >= MISSL) begin
        m_locked = 0;
        m_consec = 0;
      end
    end else if (v && m_count < (1 << PB) - 1) begin
      m_count++;
    end
`ifdef BEAT_HYSTERESIS_EN
    if (beat_ev) m_rearm = 0;
    else if (v && (s < LO) && !m_in_beat) m_rearm = 1;
`endif
    m_pulse = beat_ev || to_ev;
    m_synth = to_ev;
    m_in_beat = beat_ev;
  endfunction

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // One sample cycle: drive, clock, compare every output with the model.
  task automatic step(input logic r, input logic v, input logic [DB-1:0] s);
    rst = r;
    bus_if.sample_valid = v;
    bus_if.sample = s;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, v, int'(s));
    n_checks++;
    if (bus_if.beat_pulse !== m_pulse || bus_if.beat_synth !== m_synth ||
        bus_if.period_out !== PB'(m_pout) || bus_if.locked !== m_locked) begin
      n_fail++;
      $display("FAIL model cyc=%0d got pulse=%0b synth=%0b period=%0d locked=%0b want pulse=%0b synth=%0b period=%0d locked=%0b",
               cyc, bus_if.beat_pulse, bus_if.beat_synth, bus_if.period_out, bus_if.locked,
               m_pulse, m_synth, m_pout, m_locked);
    end
    if (bus_if.beat_pulse === 1'b1) begin
      n_pulses++;
      $display("cyc=%0d beat synth=%0b period_out=%0d locked=%0b",
               cyc, bus_if.beat_synth, bus_if.period_out, bus_if.locked);
    end
    if (n_fail >= 40) finish_tb();
  endtask

  task automatic zeros(input int n);
    repeat (n) step(1'b0, 1'b1, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  task automatic run_until_pulse(input logic [DB-1:0] s, input int bound, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, s);
      n++;
    end while (bus_if.beat_pulse !== 1'b1 && n < bound);
  endtask

  typedef struct {
    int              zeros_before;
    logic [DB-1:0]   spike;
    int              exp_period;
    bit              exp_locked;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, p0;
    logic v, r;
    logic [DB-1:0] s;
    int since, target, sel;

    // Regular 1200-sample tempo; one zero of each later gap is spent on the period_out readback.
    vecs[0] = '{1200, DB'(80000), 1185, 1'b0};
    vecs[1] = '{1199, DB'(80000), 1190, 1'b0};
    vecs[2] = '{1199, DB'(80000), 1195, 1'b0};
    vecs[3] = '{1199, DB'(80000), 1200, 1'b0};
    vecs[4] = '{1199, DB'(80000), 1200, 1'b1};

    model_reset();
    bus_if.sample_valid = 1'b0;
    bus_if.sample = '0;

    // Reset values and the silent-input timeout.
    do_reset();
    check("rst_pulse", int'(bus_if.beat_pulse), 0);
    check("rst_synth", int'(bus_if.beat_synth), 0);
    check("rst_period", int'(bus_if.period_out), MINP);
    check("rst_locked", int'(bus_if.locked), 0);
    run_until_pulse('0, 1500, n);
    check("timeout_at_count_1378", n, 1379);
    check("timeout_synth", int'(bus_if.beat_synth), 1);
    check("timeout_period", int'(bus_if.period_out), MINP);
    run_until_pulse('0, 1500, n);
    check("timeout_reload_gap", n, 1182);
    check("timeout2_synth", int'(bus_if.beat_synth), 1);

    // Table: steady spikes, averaging and lock.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      zeros(vecs[i].zeros_before);
      step(1'b0, 1'b1, vecs[i].spike);
      check("tbl_pulse", int'(bus_if.beat_pulse), 1);
      check("tbl_synth", int'(bus_if.beat_synth), 0);
      check("tbl_locked", int'(bus_if.locked), int'(vecs[i].exp_locked));
      step(1'b0, 1'b1, '0);
      check("tbl_period", int'(bus_if.period_out), vecs[i].exp_period);
    end

    // Spikes removed while locked: two synthetic beats, lock lost on the second.
    run_until_pulse('0, 1500, n);
    check("miss1_gap", n, 1378);
    check("miss1_synth", int'(bus_if.beat_synth), 1);
    check("miss1_locked", int'(bus_if.locked), 1);
    run_until_pulse('0, 1500, n);
    check("miss2_gap", n, 1201);
    check("miss2_synth", int'(bus_if.beat_synth), 1);
    check("miss2_locked", int'(bus_if.locked), 0);
    zeros(300);
    check("period_before_rst", int'(bus_if.period_out), 1200);
    step(1'b1, 1'b1, '0);
    check("midrst_period", int'(bus_if.period_out), MINP);
    check("midrst_locked", int'(bus_if.locked), 0);
    check("midrst_pulse", int'(bus_if.beat_pulse), 0);

    // Holdoff suppression, minimum-period beat, threshold boundary, reset masking a pulse.
    do_reset();
    zeros(1000);
    p0 = n_pulses;
    step(1'b0, 1'b1, DB'(80000));
    zeros(180);
    check("holdoff_no_pulse", n_pulses - p0, 0);
    step(1'b0, 1'b1, DB'(80000));
    check("minp_pulse", int'(bus_if.beat_pulse), 1);
    check("minp_synth", int'(bus_if.beat_synth), 0);
    zeros(1181);
    step(1'b0, 1'b1, DB'(HI));
    check("at_hi_no_pulse", int'(bus_if.beat_pulse), 0);
    step(1'b0, 1'b1, DB'(HI + 1));
    check("above_hi_pulse", int'(bus_if.beat_pulse), 1);
    rst = 1'b1;
    #1;
    check("pulse_masked_by_rst", int'(bus_if.beat_pulse), 0);
    step(1'b1, 1'b0, '0);
    check("after_rst_pulse", int'(bus_if.beat_pulse), 0);

    // Hysteresis: mid-level samples after a beat, then a spike past MIN_PERIOD.
    do_reset();
    zeros(1200);
    step(1'b0, 1'b1, DB'(80000));
    check("hyst_first_pulse", int'(bus_if.beat_pulse), 1);
    repeat (1181) step(1'b0, 1'b1, DB'(50000));
    run_until_pulse(DB'(80000), 400, n);
`ifdef BEAT_HYSTERESIS_EN
    check("hyst_gap", n, 198);
    check("hyst_synth", int'(bus_if.beat_synth), 1);
`else
    check("hyst_gap", n, 1);
    check("hyst_synth", int'(bus_if.beat_synth), 0);
`endif

    // Randomised traffic with a loose underlying tempo, boundary levels and rare resets.
    do_reset();
    since = 0;
    target = $urandom_range(1150, 1420);
    for (int i = 0; i < 16000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 3999) == 0);
      sel = $urandom_range(0, 99);
      if (v && since >= target) begin
        s = DB'(HI + 1 + $urandom_range(0, 60000));
        since = 0;
        target = $urandom_range(1150, 1420);
      end else if (sel < 3) s = DB'(HI);
      else if (sel < 6)  s = DB'(LO);
      else if (sel < 9)  s = DB'(LO - 1);
      else if (sel < 10) s = DB'(HI + 1);
      else if (sel < 35) s = DB'(LO + $urandom_range(0, HI - LO));
      else               s = DB'($urandom_range(0, LO - 1));
      if (v) since++;
      step(r, v, s);
    end

    finish_tb();
  end
endmodule
